// File: rtl/msu_pkg.sv
// Shared state encoding, flag positions and frame sizing
// for the checkpointing modular-squaring controller.
package msu_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_RECV,
        S_LOAD,
        S_START,
        S_COMPUTE,
        S_DRAIN,
        S_SEND_FINAL,
        S_DONE
    } state_t;

    localparam int F_FINAL   = 0;
    localparam int F_TIMEOUT = 1;
    localparam int F_ABORT   = 2;
    localparam int F_CKPT    = 3;
    localparam int F_OVERRUN = 4;

    localparam int DAT_BITS = 1024;
    localparam int TOT_BITS = 1056;

    function automatic int in_words(input int axi_len, input int t_len,
                                    input int sq_bits);
        return (3 * t_len + sq_bits + axi_len - 1) / axi_len;
    endfunction

    function automatic int out_words(input int axi_len, input int t_len,
                                     input int sq_bits);
        return (t_len + axi_len + sq_bits + axi_len - 1) / axi_len;
    endfunction

endpackage

// File: rtl/msu_axis_tx.sv
// Result-frame serializer: loads a whole frame and shifts it out
// one AXI word per accepted beat, LSB word first.
module msu_axis_tx #(
    parameter int AXI_LEN = 32,
    parameter int OW      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [OW*AXI_LEN-1:0]  data,
    output logic                   busy,
    output logic                   last_acc,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXI_LEN-1:0]     m_axis_tdata,
    output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast
);

    localparam int CW = $clog2(OW + 1);

    logic [AXI_LEN-1:0] w [OW];
    logic [CW-1:0]      cnt;
    logic               vld;
    logic               acc;

    assign m_axis_tvalid = vld;
    assign m_axis_tdata  = w[0];
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = vld && (cnt == CW'(OW - 1));
    assign busy          = vld;
    assign acc           = vld && m_axis_tready;
    assign last_acc      = acc && m_axis_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            cnt <= '0;
            for (int i = 0; i < OW; i++) w[i] <= '0;
        end else if (load && !vld) begin
            vld <= 1'b1;
            cnt <= '0;
            for (int i = 0; i < OW; i++) w[i] <= data[i*AXI_LEN +: AXI_LEN];
        end else if (acc) begin
            if (m_axis_tlast) begin
                vld <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
                for (int i = 0; i < OW - 1; i++) w[i] <= w[i+1];
                w[OW-1] <= '0;
            end
        end
    end

endmodule

// File: rtl/msu_ckpt.sv
// MSU controller: receives a job frame, drives the squarer and
// streams checkpoint and terminal result frames.
module msu_ckpt
    import msu_pkg::*;
#(
    parameter int AXI_LEN           = 32,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int T_LEN             = 64,
    parameter int SQ_IN_BITS        = DAT_BITS,
    parameter int SQ_OUT_BITS       = TOT_BITS,
    parameter int TIMEOUT_BITS      = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic [AXI_LEN-1:0]           s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]         s_axis_tkeep,
    output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [AXI_LEN-1:0]           m_axis_tdata,
    output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
    output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
    input  logic                         ap_start,
    input  logic                         ap_abort,
    output logic                         ap_done,
    output logic                         start_xfer,
    output logic [SQ_IN_BITS-1:0]        sq_in,
    output logic                         sq_start,
    output logic                         sq_reset,
    input  logic [SQ_OUT_BITS-1:0]       sq_out,
    input  logic                         sq_valid,
    input  logic                         sq_locked
);

    localparam int IW = in_words(AXI_LEN, T_LEN, SQ_IN_BITS);
    localparam int OW = out_words(AXI_LEN, T_LEN, SQ_OUT_BITS);
    localparam int FW = OW * AXI_LEN;
    localparam int RW = $clog2(IW + 1);

    logic [1:0]              rst_q;
    logic                    rst_n;
    state_t                  state, state_n;
    logic [AXI_LEN-1:0]      rx [IW];
    logic [RW-1:0]           rx_cnt;
    logic [IW*AXI_LEN-1:0]   flat;
    logic [T_LEN-1:0]        t_cur, t_fin, ival, ckpt_cnt;
    logic [T_LEN-1:0]        t_next, t_ev;
    logic [SQ_OUT_BITS-1:0]  sq_q, sq_ev;
    logic [TIMEOUT_BITS-1:0] timer;
    logic                    ovr;
    logic [FW-1:0]           pend, tx_data;
    logic [AXI_LEN-1:0]      fl_ck, fl_term;
    logic                    tx_load, tx_busy, tx_last_acc;
    logic                    rx_fire, in_comp, fin, ck, tmo, term;
    logic                    unused_ok;

    assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IW * AXI_LEN / 8);
    assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OW * AXI_LEN / 8);
    assign unused_ok = ^{s_axis_tkeep, flat};

    // Reset asserts asynchronously, releases two clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_q <= 2'b00;
        else          rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    always_comb begin
        for (int i = 0; i < IW; i++) flat[i*AXI_LEN +: AXI_LEN] = rx[i];
    end

    assign s_axis_tready = (state == S_RECV) && sq_locked;
    assign rx_fire  = s_axis_tvalid && s_axis_tready;
    assign sq_start = (state == S_START);
    assign ap_done  = (state == S_DONE);
    assign sq_reset = (state == S_INIT) || (state == S_RECV) ||
                      (state == S_DRAIN) || (state == S_SEND_FINAL) ||
                      (state == S_DONE);

    assign in_comp = (state == S_COMPUTE);
    assign t_next  = t_cur + T_LEN'(1);
    assign fin     = in_comp && sq_valid && (t_next == t_fin);
    assign ck      = in_comp && sq_valid && (ival != '0) &&
                     (ckpt_cnt == T_LEN'(1));
    assign tmo     = in_comp && (&timer);
    assign term    = fin || (in_comp && ap_abort) || tmo;
    assign t_ev    = sq_valid ? t_next : t_cur;
    assign sq_ev   = sq_valid ? sq_out : sq_q;

    always_comb begin
        fl_ck            = '0;
        fl_ck[F_CKPT]    = 1'b1;
        fl_ck[F_OVERRUN] = ovr;
        fl_term            = '0;
        fl_term[F_FINAL]   = 1'b1;
        fl_term[F_TIMEOUT] = tmo;
        fl_term[F_ABORT]   = ap_abort;
        fl_term[F_CKPT]    = ck;
        fl_term[F_OVERRUN] = ovr;
    end

    always_comb begin
        state_n = state;
        tx_load = 1'b0;
        tx_data = pend;
        unique case (state)
            S_INIT:    if (ap_start) state_n = S_RECV;
            S_RECV:    if (rx_fire && s_axis_tlast) state_n = S_LOAD;
            S_LOAD:    state_n = S_START;
            S_START:   state_n = S_COMPUTE;
            S_COMPUTE: begin
                if (term) begin
                    state_n = S_DRAIN;
                end else if (ck && !tx_busy) begin
                    tx_load = 1'b1;
                    tx_data = FW'({sq_ev, fl_ck, t_ev});
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    state_n = S_SEND_FINAL;
                end
            end
            S_SEND_FINAL: if (tx_last_acc) state_n = S_DONE;
            S_DONE:    state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            rx_cnt     <= '0;
            t_cur      <= '0;
            t_fin      <= '0;
            ival       <= '0;
            ckpt_cnt   <= '0;
            sq_in      <= '0;
            sq_q       <= '0;
            timer      <= '0;
            ovr        <= 1'b0;
            pend       <= '0;
            start_xfer <= 1'b0;
            for (int i = 0; i < IW; i++) rx[i] <= '0;
        end else begin
            state      <= state_n;
            start_xfer <= tx_load;
            timer      <= (in_comp && !sq_valid) ?
                          timer + TIMEOUT_BITS'(1) : '0;
            unique case (state)
                S_INIT: begin
                    rx_cnt <= '0;
                    for (int i = 0; i < IW; i++) rx[i] <= '0;
                end
                S_RECV: begin
                    if (rx_fire) begin
                        if (rx_cnt < RW'(IW)) begin
                            rx_cnt <= rx_cnt + RW'(1);
                            for (int i = 0; i < IW; i++)
                                if (rx_cnt == RW'(i)) rx[i] <= s_axis_tdata;
                        end else begin
                            // Overlong frames keep only the newest words.
                            for (int i = 0; i < IW - 1; i++) rx[i] <= rx[i+1];
                            rx[IW-1] <= s_axis_tdata;
                        end
                    end
                end
                S_LOAD: begin
                    t_cur    <= flat[T_LEN-1:0];
                    t_fin    <= flat[2*T_LEN-1:T_LEN];
                    ival     <= flat[3*T_LEN-1:2*T_LEN];
                    ckpt_cnt <= flat[3*T_LEN-1:2*T_LEN];
                    sq_in    <= flat[3*T_LEN +: SQ_IN_BITS];
                    sq_q     <= '0;
                    ovr      <= 1'b0;
                end
                S_COMPUTE: begin
                    if (sq_valid) begin
                        t_cur    <= t_next;
                        sq_q     <= sq_out;
                        ckpt_cnt <= (ckpt_cnt == T_LEN'(1)) ?
                                    ival : ckpt_cnt - T_LEN'(1);
                    end
                    if (term) begin
                        pend <= FW'({sq_ev, fl_term, t_ev});
                        ovr  <= 1'b0;
                    end else if (ck) begin
                        ovr <= tx_busy;
                    end
                end
                default: ;
            endcase
        end
    end

    msu_axis_tx #(
        .AXI_LEN (AXI_LEN),
        .OW      (OW)
    ) u_tx (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (tx_load),
        .data          (tx_data),
        .busy          (tx_busy),
        .last_acc      (tx_last_acc),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

endmodule

// File: tb/tb_msu_ckpt.sv
// Scoreboard bench for msu_ckpt with a behavioural squarer model.
module tb_msu_ckpt;

    localparam int AXI = 32;
    localparam int TL  = 64;
    localparam int SQI = 32;
    localparam int SQO = 40;

    typedef struct {
        logic [63:0] t;
        logic [31:0] fl;
        logic [39:0] sq;
    } frame_t;

    logic            clk = 0;
    logic            reset_n = 0;
    logic            s_axis_tvalid = 0;
    logic            s_axis_tready;
    logic            s_axis_tlast = 0;
    logic [31:0]     s_axis_tdata = 0;
    logic [3:0]      s_axis_tkeep = '1;
    logic [31:0]     s_xfer;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1;
    logic            m_axis_tlast;
    logic [31:0]     m_axis_tdata;
    logic [3:0]      m_axis_tkeep;
    logic [31:0]     m_xfer;
    logic            ap_start = 0;
    logic            ap_abort = 0;
    logic            ap_done;
    logic            start_xfer;
    logic [SQI-1:0]  sq_in;
    logic            sq_start;
    logic            sq_reset;
    logic [SQO-1:0]  sq_out = 0;
    logic            sq_valid = 0;
    logic            sq_locked = 1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int start_cyc = 0;
    int tv_rise = 0;
    int lat = 3;
    bit sq_en = 1;
    int mk = 0;
    int mcyc = 0;
    bit mrun = 0;
    frame_t exp_q[$];

    msu_ckpt #(
        .AXI_LEN           (AXI),
        .C_XFER_SIZE_WIDTH (32),
        .T_LEN             (TL),
        .SQ_IN_BITS        (SQI),
        .SQ_OUT_BITS       (SQO),
        .TIMEOUT_BITS      (4)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .s_axis_tvalid             (s_axis_tvalid),
        .s_axis_tready             (s_axis_tready),
        .s_axis_tlast              (s_axis_tlast),
        .s_axis_tdata              (s_axis_tdata),
        .s_axis_tkeep              (s_axis_tkeep),
        .s_axis_xfer_size_in_bytes (s_xfer),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tready             (m_axis_tready),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tkeep              (m_axis_tkeep),
        .m_axis_xfer_size_in_bytes (m_xfer),
        .ap_start                  (ap_start),
        .ap_abort                  (ap_abort),
        .ap_done                   (ap_done),
        .start_xfer                (start_xfer),
        .sq_in                     (sq_in),
        .sq_start                  (sq_start),
        .sq_reset                  (sq_reset),
        .sq_out                    (sq_out),
        .sq_valid                  (sq_valid),
        .sq_locked                 (sq_locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [39:0] res(input logic [31:0] s, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {kb, s + 32'(k)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Squarer model: one result every lat cycles after sq_start.
    always @(posedge clk) begin
        sq_valid <= 1'b0;
        if (sq_reset) begin
            mrun <= 0;
            mk   <= 0;
            mcyc <= 0;
        end else if (sq_start) begin
            mrun <= 1;
            mcyc <= 0;
        end else if (mrun && sq_en) begin
            if (mcyc == lat - 1) begin
                mcyc     <= 0;
                mk       <= mk + 1;
                sq_valid <= 1'b1;
                sq_out   <= res(sq_in, mk + 1);
            end else begin
                mcyc <= mcyc + 1;
            end
        end
    end

    logic [159:0] fbuf;
    int           nbeats = 0;
    bit           held = 0;
    bit           prev_tv = 0;
    logic [31:0]  hold_d;

    always @(negedge clk) begin
        if (!reset_n) begin
            nbeats  = 0;
            held    = 0;
            prev_tv = 0;
        end else begin
            if (ap_done) done_cnt++;
            if (m_axis_tvalid && !prev_tv) tv_rise = cyc;
            prev_tv = m_axis_tvalid;
            if (m_axis_tvalid && !m_axis_tready) begin
                if (held) chk("hold_stable", 64'(m_axis_tdata), 64'(hold_d));
                held   = 1;
                hold_d = m_axis_tdata;
            end else begin
                held = 0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (nbeats < 5) fbuf[nbeats*32 +: 32] = m_axis_tdata;
                nbeats++;
                if (m_axis_tlast) begin
                    frame_t e;
                    chk("frame_len", 64'(nbeats), 5);
                    chk("frame_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_t", fbuf[63:0], e.t);
                        chk("frame_flags", 64'(fbuf[95:64]), 64'(e.fl));
                        chk("frame_sq", 64'(fbuf[135:96]), 64'(e.sq));
                        chk("frame_pad", 64'(fbuf[159:136]), 0);
                    end
                    nbeats = 0;
                end
            end
        end
    end

    task automatic push(input logic [63:0] t, input logic [31:0] fl,
                        input logic [39:0] sq);
        frame_t e;
        e.t  = t;
        e.fl = fl;
        e.sq = sq;
        exp_q.push_back(e);
    endtask

    task automatic send_job(input logic [63:0] ts, input logic [63:0] tf,
                            input logic [63:0] iv, input logic [31:0] si);
        logic [223:0] v;
        int n;
        v = {si, iv, tf, ts};
        ap_start = 1;
        for (int w = 0; w < 7; w++) begin
            s_axis_tdata  = v[w*32 +: 32];
            s_axis_tvalid = 1;
            s_axis_tlast  = (w == 6);
            n = 0;
            @(negedge clk);
            while (!s_axis_tready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!s_axis_tready) chk("s_tready_wait", 0, 1);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
        ap_start      = 0;
        @(negedge clk);
        chk("sq_start_load", 64'(sq_start), 0);
        @(negedge clk);
        chk("sq_start_pulse", 64'(sq_start), 1);
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        exp_done++;
        while (done_cnt < exp_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(done_cnt), 64'(exp_done));
        repeat (5) @(negedge clk);
        chk({name, "_once"}, 64'(done_cnt), 64'(exp_done));
        chk({name, "_drained"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3;
        chk("rst_tvalid", 64'(m_axis_tvalid), 0);
        chk("rst_sq_reset", 64'(sq_reset), 1);
        chk("rst_s_tready", 64'(s_axis_tready), 0);
        chk("rst_ap_done", 64'(ap_done), 0);
        chk("rst_start_xfer", 64'(start_xfer), 0);
        chk("s_xfer_size", 64'(s_xfer), 28);
        chk("m_xfer_size", 64'(m_xfer), 20);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        repeat (4) @(posedge clk);
        #1;

        // single final frame
        lat = 3;
        push(4, 32'h1, res(32'h12345678, 4));
        send_job(0, 4, 0, 32'h12345678);
        wait_done("done_basic");

        // checkpoints every 2
        push(2, 32'h8, res(32'hCAFE0001, 2));
        push(4, 32'h8, res(32'hCAFE0001, 4));
        push(6, 32'h9, res(32'hCAFE0001, 6));
        send_job(0, 6, 2, 32'hCAFE0001);
        wait_done("done_ckpt");

        // backpressure drops checkpoints
        lat = 12;
        m_axis_tready = 0;
        push(1, 32'h8, res(32'h0BAD0000, 1));
        push(6, 32'h18, res(32'h0BAD0000, 6));
        push(7, 32'h8, res(32'h0BAD0000, 7));
        push(8, 32'h9, res(32'h0BAD0000, 8));
        send_job(0, 8, 1, 32'h0BAD0000);
        n = 0;
        while (!m_axis_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ovr_first_tvalid", 64'(m_axis_tvalid), 1);
        repeat (50) @(posedge clk);
        #1 m_axis_tready = 1;
        wait_done("done_overrun");

        // host abort at t_current=3
        lat = 3;
        push(3, 32'h5, res(32'h00C0FFEE, 3));
        send_job(0, 50, 0, 32'h00C0FFEE);
        n = 0;
        while (mk < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ap_abort = 1;
        @(posedge clk);
        #1 ap_abort = 0;
        @(negedge clk);
        chk("sq_reset_after_abort", 64'(sq_reset), 1);
        wait_done("done_abort");

        // squarer stall -> timeout
        sq_en = 0;
        push(7, 32'h3, 0);
        send_job(7, 100, 0, 32'h55AA55AA);
        wait_done("done_timeout");
        chk("timeout_delay_ok",
            64'((tv_rise - start_cyc) >= 16 && (tv_rise - start_cyc) <= 20), 1);
        sq_en = 1;

        // reset mid-frame
        m_axis_tready = 0;
        send_job(0, 100, 1, 32'h77777777);
        n = 0;
        while (!m_axis_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_tvalid", 64'(m_axis_tvalid), 1);
        @(posedge clk);
        #1 m_axis_tready = 1;
        repeat (2) @(posedge clk);
        #1 m_axis_tready = 0;
        #2 reset_n = 0;
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 0);
        chk("midrst_tlast", 64'(m_axis_tlast), 0);
        chk("midrst_sq_reset", 64'(sq_reset), 1);
        repeat (3) @(posedge clk);
        #1;
        sq_locked = 0;
        ap_start  = 1;
        reset_n   = 1;
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            chk("unlocked_s_tready", 64'(s_axis_tready), 0);
        end
        sq_locked = 1;
        m_axis_tready = 1;
        @(negedge clk);
        chk("locked_s_tready", 64'(s_axis_tready), 1);
        @(posedge clk);
        #1;
        push(4, 32'h1, res(32'h0000ABCD, 4));
        send_job(0, 4, 0, 32'h0000ABCD);
        wait_done("done_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
